// File: rtl/fft_seq_ctrl_if.sv
// fft_seq_ctrl_if: handshake, RAM and stream signals of the FFT control sequencer
interface fft_seq_ctrl_if #(parameter int LOG2N = 10);
  logic             start_i;
  logic             unload_i;
  logic             abort_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic             bf_start_o;
  logic             bf_done_i;
  logic             mem_re_o;
  logic             mem_we_o;
  logic [LOG2N-1:0] mem_addr_o;
  logic [1:0]       mem_wsel_o;
  logic [LOG2N-2:0] tw_idx_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             busy_o;
  logic             done_o;
  modport master (
    output start_i, unload_i, abort_i, in_valid_i, bf_done_i, out_ready_i,
    input  in_ready_o, bf_start_o, mem_re_o, mem_we_o, mem_addr_o, mem_wsel_o,
           tw_idx_o, out_valid_o, busy_o, done_o
  );
  modport slave (
    input  start_i, unload_i, abort_i, in_valid_i, bf_done_i, out_ready_i,
    output in_ready_o, bf_start_o, mem_re_o, mem_we_o, mem_addr_o, mem_wsel_o,
           tw_idx_o, out_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: load/compute/unload sequencer for an in-place radix-2 DIT FFT
module fft_seq_ctrl #(
  parameter int LOG2N = 10
) (
  input logic           clk_i,
  input logic           rst_ni,
  fft_seq_ctrl_if.slave io
);
  localparam int SW = $clog2(LOG2N);
  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LOAD    = 4'd1;
  localparam logic [3:0] RD_A    = 4'd2;
  localparam logic [3:0] RD_B    = 4'd3;
  localparam logic [3:0] CALC    = 4'd4;
  localparam logic [3:0] WR_A    = 4'd5;
  localparam logic [3:0] WR_B    = 4'd6;
  localparam logic [3:0] DONE    = 4'd7;
  localparam logic [3:0] UNL_RD  = 4'd8;
  localparam logic [3:0] UNL_OUT = 4'd9;
  logic [3:0]       st;
  logic [LOG2N-1:0] k;
  logic [SW-1:0]    s;
  logic [LOG2N-2:0] b;
  logic             first;
  logic [LOG2N-1:0] kr, half, j, addr_a, addr_b;
  logic [LOG2N-2:0] tw;
  logic [SW-1:0]    ts;
  logic             last_k, last_b, last_s;
  // addr_a is b with a zero bit inserted at position s; addr_b sets that bit
  always_comb begin
    for (int i = 0; i < LOG2N; i++) kr[i] = k[LOG2N-1-i];
    half   = LOG2N'(1) << s;
    j      = {1'b0, b} & (half - LOG2N'(1));
    addr_a = (({1'b0, b} >> s) << s << 1) | j;
    addr_b = addr_a | half;
    ts     = SW'(LOG2N - 1) - s;
    tw     = j[LOG2N-2:0] << ts;
    last_k = k == '1;
    last_b = b == '1;
    last_s = s == SW'(LOG2N - 1);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st    <= IDLE;
      k     <= '0;
      s     <= '0;
      b     <= '0;
      first <= 1'b0;
    end else if (io.abort_i && st != IDLE) begin
      st    <= IDLE;
      k     <= '0;
      s     <= '0;
      b     <= '0;
      first <= 1'b0;
    end else begin
      first <= st == RD_B;
      case (st)
        IDLE: begin
          if (io.start_i || io.unload_i) begin
            st <= io.start_i ? LOAD : UNL_RD;
            k  <= '0;
            s  <= '0;
            b  <= '0;
          end
        end
        LOAD: begin
          if (io.in_valid_i) begin
            k <= k + LOG2N'(1);
            if (last_k) st <= RD_A;
          end
        end
        RD_A:   st <= RD_B;
        RD_B:   st <= CALC;
        CALC:   if (io.bf_done_i) st <= WR_A;
        WR_A:   st <= WR_B;
        WR_B: begin
          if (!last_b) begin
            b  <= b + (LOG2N-1)'(1);
            st <= RD_A;
          end else if (!last_s) begin
            b  <= '0;
            s  <= s + SW'(1);
            st <= RD_A;
          end else begin
            st <= DONE;
          end
        end
        DONE:   st <= IDLE;
        UNL_RD: st <= UNL_OUT;
        UNL_OUT: begin
          if (io.out_ready_i) begin
            st <= last_k ? IDLE : UNL_RD;
            if (!last_k) k <= k + LOG2N'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
  assign io.in_ready_o  = st == LOAD;
  assign io.bf_start_o  = st == CALC && first;
  assign io.mem_re_o    = st inside {RD_A, RD_B, UNL_RD};
  assign io.mem_we_o    = (st == LOAD && io.in_valid_i) || st == WR_A || st == WR_B;
  assign io.mem_addr_o  = st == LOAD ? kr :
                          st inside {RD_A, WR_A} ? addr_a :
                          st inside {RD_B, WR_B} ? addr_b :
                          st == UNL_RD ? k : '0;
  assign io.mem_wsel_o  = st == WR_A ? 2'd1 : st == WR_B ? 2'd2 : 2'd0;
  assign io.tw_idx_o    = st inside {RD_A, RD_B, CALC, WR_A, WR_B} ? tw : '0;
  assign io.out_valid_o = st == UNL_OUT;
  assign io.busy_o      = st != IDLE;
  assign io.done_o      = st == DONE;
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: scoreboard bench for fft_seq_ctrl at LOG2N=3 with randomized handshakes
module tb_fft_seq_ctrl;
  localparam int LOG2N = 3;
  localparam int N = 1 << LOG2N;
  localparam int KW = 0, KR = 1, KS = 2, KD = 3, KO = 4;
  typedef struct {int kind; int addr; int wsel; int tw;} ev_t;
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;
  fft_seq_ctrl_if #(.LOG2N(LOG2N)) io();
  fft_seq_ctrl #(.LOG2N(LOG2N)) dut (.clk_i(clk), .rst_ni(rst_ni), .io(io));
  ev_t q[$];
  int checks = 0, errors = 0;
  int lat = 1;
  bit unl_phase = 0;
  bit stall_prev = 0;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  function automatic void push(int kind, int addr, int wsel, int tw);
    ev_t e;
    e.kind = kind; e.addr = addr; e.wsel = wsel; e.tw = tw;
    q.push_back(e);
  endfunction
  function automatic int bitrev(int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction
  function automatic void push_load(int cnt);
    for (int i = 0; i < cnt; i++) push(KW, bitrev(i), 0, 0);
  endfunction
  // Reference: every butterfly of every stage, in order, from the index arithmetic
  function automatic void push_compute();
    for (int st = 0; st < LOG2N; st++)
      for (int bf = 0; bf < N / 2; bf++) begin
        int half = 1 << st;
        int jj = bf % half;
        int a = (bf / half) * 2 * half + jj;
        int t = jj * (N / 2) / half;
        push(KR, a, 0, t);
        push(KR, a + half, 0, t);
        push(KS, 0, 0, t);
        push(KW, a, 1, t);
        push(KW, a + half, 2, t);
      end
    push(KD, 0, 0, 0);
  endfunction
  function automatic int outs();
    return int'({io.in_ready_o, io.bf_start_o, io.mem_re_o, io.mem_we_o, io.mem_addr_o,
                 io.mem_wsel_o, io.tw_idx_o, io.out_valid_o, io.busy_o, io.done_o});
  endfunction
  // bf_done_i responder: fixed latency, or random 0..3 when lat is negative
  initial begin
    int l;
    io.bf_done_i = 1'b0;
    forever begin
      step();
      if (io.bf_start_o) begin
        l = lat < 0 ? int'($urandom_range(0, 3)) : lat;
        repeat (l) step();
        io.bf_done_i = 1'b1;
        step();
        io.bf_done_i = 1'b0;
      end
    end
  end
  // Monitor: every observable transaction pops one expected entry
  always @(negedge clk) begin
    ev_t g, e;
    if (!rst_ni) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) chk("out_valid_held", int'(io.out_valid_o), 1);
      stall_prev = io.out_valid_o && !io.out_ready_i && !io.abort_i;
      if (io.bf_start_o || io.done_o || io.mem_we_o || io.mem_re_o || (io.out_valid_o && io.out_ready_i)) begin
        g.kind = io.bf_start_o ? KS : io.done_o ? KD : io.mem_we_o ? KW : io.mem_re_o ? KR : KO;
        g.addr = (io.mem_we_o || io.mem_re_o) ? int'(io.mem_addr_o) : 0;
        g.wsel = io.mem_we_o ? int'(io.mem_wsel_o) : 0;
        g.tw   = ((io.mem_re_o && !unl_phase) || io.bf_start_o || (io.mem_we_o && io.mem_wsel_o != 2'd0)) ? int'(io.tw_idx_o) : 0;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL event: unexpected kind=%0d addr=%0d wsel=%0d tw=%0d", g.kind, g.addr, g.wsel, g.tw);
        end else begin
          e = q.pop_front();
          if (e.kind != g.kind || e.addr != g.addr || e.wsel != g.wsel || e.tw != g.tw) begin
            errors++;
            $display("FAIL event: got kind=%0d addr=%0d wsel=%0d tw=%0d, expected kind=%0d addr=%0d wsel=%0d tw=%0d",
                     g.kind, g.addr, g.wsel, g.tw, e.kind, e.addr, e.wsel, e.tw);
          end
        end
      end
    end
  end
  task automatic do_load(int cnt, bit rnd);
    int hs = 0, guard = 0;
    io.start_i = 1'b1;
    step();
    io.start_i = 1'b0;
    chk("in_ready_in_load", int'(io.in_ready_o), 1);
    while (hs < cnt && guard < 200) begin
      io.in_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (io.in_valid_i) hs++;
      guard++;
    end
    io.in_valid_i = 1'b0;
  endtask
  task automatic run_compute(int exp_n, bit rnd);
    int n = 1;
    push_load(N);
    push_compute();
    step();
    do_load(N, rnd);
    while (!io.done_o && n < 2000) begin
      io.start_i  = n == 20;
      io.unload_i = n == 20;
      step();
      n++;
    end
    io.start_i = 1'b0;
    io.unload_i = 1'b0;
    chk("done_reached", int'(io.done_o), 1);
    if (exp_n > 0) chk("compute_cycles", n, exp_n);
    step();
    chk("done_one_cycle", int'(io.done_o), 0);
    chk("idle_after_done", int'(io.busy_o), 0);
    chk("queue_drained", q.size(), 0);
  endtask
  task automatic run_unload(bit rnd);
    int n = 0;
    bit tog = 1'b1;
    unl_phase = 1;
    for (int i = 0; i < N; i++) begin
      push(KR, i, 0, 0);
      push(KO, 0, 0, 0);
    end
    step();
    io.unload_i = 1'b1;
    step();
    io.unload_i = 1'b0;
    while (io.busy_o && n < 200) begin
      io.out_ready_i = rnd ? 1'($urandom_range(0, 1)) : tog;
      tog = !tog;
      step();
      n++;
    end
    io.out_ready_i = 1'b0;
    chk("unload_idle", int'(io.busy_o), 0);
    chk("unload_drained", q.size(), 0);
    unl_phase = 0;
  endtask
  initial begin
    int n;
    rst_ni = 1'b0;
    io.start_i = 1'b0; io.unload_i = 1'b0; io.abort_i = 1'b0;
    io.in_valid_i = 1'b0; io.out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst_ni = 1'b1;
    step();
    chk("post_reset_outputs", outs(), 0);
    // start and unload together go to LOAD; start/unload pulsed mid-compute are ignored
    step();
    io.start_i = 1'b1;
    io.unload_i = 1'b1;
    push_load(N);
    push_compute();
    step();
    io.start_i = 1'b0;
    io.unload_i = 1'b0;
    chk("start_wins", int'(io.in_ready_o), 1);
    repeat (N) begin io.in_valid_i = 1'b1; step(); end
    io.in_valid_i = 1'b0;
    n = 1;
    while (!io.done_o && n < 2000) begin
      io.start_i = n == 20;
      step();
      n++;
    end
    io.start_i = 1'b0;
    chk("compute_cycles_l1", n, 73);
    step();
    chk("done_pulse_width", int'(io.done_o), 0);
    chk("queue_drained_a", q.size(), 0);
    lat = 5;
    run_compute(121, 0);
    run_unload(0);
    // abort in LOAD after three samples, then a fresh full run from address 0
    lat = 1;
    push_load(3);
    step();
    io.start_i = 1'b1;
    step();
    io.start_i = 1'b0;
    repeat (3) begin io.in_valid_i = 1'b1; step(); end
    io.in_valid_i = 1'b0;
    io.abort_i = 1'b1;
    step();
    io.abort_i = 1'b0;
    chk("abort_load_idle", int'(io.busy_o), 0);
    chk("abort_load_drained", q.size(), 0);
    run_compute(73, 0);
    // abort on the first CALC cycle
    lat = 3;
    push_load(N);
    push(KR, 0, 0, 0);
    push(KR, 1, 0, 0);
    push(KS, 0, 0, 0);
    step();
    do_load(N, 0);
    n = 0;
    while (!io.bf_start_o && n < 10) begin step(); n++; end
    chk("reached_calc", int'(io.bf_start_o), 1);
    io.abort_i = 1'b1;
    step();
    io.abort_i = 1'b0;
    chk("abort_calc_idle", int'(io.busy_o), 0);
    repeat (6) begin step(); chk("abort_no_done", int'(io.done_o), 0); end
    chk("abort_calc_drained", q.size(), 0);
    // randomized valid gaps, butterfly latency and output backpressure
    lat = -1;
    repeat (2) begin
      run_compute(-1, 1);
      run_unload(1);
    end
    // asynchronous reset mid-compute
    lat = 1;
    push_load(N);
    push_compute();
    step();
    do_load(N, 0);
    repeat (10) step();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 0);
    q.delete();
    step();
    rst_ni = 1'b1;
    repeat (3) step();
    chk("after_reset_idle", int'(io.busy_o), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Parametrised control sequencer for an in-place radix-2 decimation-in-time FFT of N = 2^LOG2N points. It is the next generation of the fixed FFT control FSM and adds:
- internal sample, stage and butterfly counters;
- bit-reversed load addressing;
- butterfly address and twiddle index generation;
- valid/ready input and output streams;
- an abort path.

It sits between the sample RAM, the butterfly datapath and the bus-side load/unload logic.

## Interface
- LOG2N, default 10: log2 of the FFT length. Legal range is 2..12.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  starts load followed by compute. Sampled only in IDLE.
- unload_i  in  1  starts readout of results. Sampled only in IDLE.
- abort_i  in  1  returns the block to IDLE from any state.
- in_valid_i  in  1  input sample valid.
- in_ready_o  out  1  high in LOAD.
- bf_start_o  out  1  one-cycle butterfly start pulse.
- bf_done_i  in  1  butterfly result ready.
- mem_re_o  out  1  RAM read enable. The RAM is synchronous with 1-cycle read latency.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  LOG2N  RAM address.
- mem_wsel_o  out  2  write data source: 0 = input sample, 1 = butterfly result A, 2 = butterfly result B.
- tw_idx_o  out  LOG2N-1  twiddle ROM index.
- out_valid_o  out  1  output sample valid. Data is the RAM read port.
- out_ready_i  in  1  output sample accepted.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at compute completion.

## Operation
- States: IDLE, LOAD, RD_A, RD_B, CALC, WR_A, WR_B, DONE, UNL_RD, UNL_OUT.
- Counters:
  - sample counter k, LOG2N bits;
  - stage counter s, 0..LOG2N-1;
  - butterfly counter b, 0..N/2-1.
- All counters clear on entry to LOAD and UNL_RD from IDLE, on abort and on reset.
- IDLE:
  - start_i moves to LOAD.
  - Otherwise unload_i moves to UNL_RD.
  - start_i wins when both are high.
- LOAD:
  - in_ready_o=1.
  - mem_we_o = in_valid_i; mem_wsel_o=0; mem_addr_o = bitrev(k).
  - On handshake k increments.
  - The handshake with k=N-1 moves to RD_A.
- Butterfly addressing:
  - half = 2^s, j = b mod half, g = b >> s.
  - addr_a = g*2^(s+1) + j; addr_b = addr_a + half.
  - tw_idx_o = j << (LOG2N-1-s). tw_idx_o is held valid RD_A through WR_B.
- RD_A: mem_re_o=1, addr_a. Always goes to RD_B.
- RD_B: mem_re_o=1, addr_b. Always goes to CALC.
- CALC:
  - bf_start_o=1 in the first CALC cycle only.
  - bf_done_i is accepted on any CALC cycle, the first included, and moves to WR_A.
  - bf_done_i is ignored in all other states.
- WR_A: mem_we_o=1, wsel=1, addr_a. Goes to WR_B.
- WR_B: mem_we_o=1, wsel=2, addr_b. Then:
  - if b<N/2-1: b increments, go to RD_A;
  - else if s<LOG2N-1: b=0, s increments, go to RD_A;
  - else go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- UNL_RD: mem_re_o=1, addr=k. Goes to UNL_OUT.
- UNL_OUT:
  - out_valid_o=1, held until out_ready_i.
  - On acceptance with k<N-1: k increments, go to UNL_RD.
  - On acceptance with k=N-1: go to IDLE.
  - Unload produces no done_o.
- abort_i has highest priority in every non-IDLE state:
  - next state IDLE, counters cleared, no done_o;
  - RAM contents are undefined for compute.
- start_i and unload_i outside IDLE are ignored.

## Timing
- Reset values:
  - state IDLE; all counters 0;
  - every output 0, including mem_addr_o, mem_wsel_o and tw_idx_o.
- All outputs decode from registered state and counters, except LOAD mem_we_o, which follows in_valid_i combinationally.
- Load takes N handshake cycles minimum.
- Per butterfly: 5 + L cycles, where L = cycles from bf_start_o to bf_done_i (L ≥ 0; L=0 means done on the start cycle).
- Compute total is LOG2N·N/2·(5+L) cycles, plus 1 DONE cycle.
- Unload takes 2 cycles per sample when out_ready_i is held high.
- Reset asserted mid-operation forces IDLE and all outputs to 0 immediately (asynchronous).

## Test plan
- LOG2N=3, reset release: all outputs 0, busy_o=0. Then start_i with 8 continuous valid samples -> write addresses 0,4,2,6,1,5,3,7 with wsel=0, and RD_A on the next cycle.
- LOG2N=3, bf_done_i 1 cycle after bf_start_o:
  - butterfly (s,b) = (0,0) -> addresses 0/1, tw 0;
  - (1,1) -> 1/3, tw 2;
  - (2,3) -> 3/7, tw 3;
  - 12 butterflies in 72 cycles, then done_o for exactly one cycle.
- Butterfly stall: bf_done_i delayed 5 cycles -> CALC is held, bf_start_o stays a single pulse, no write occurs before bf_done_i.
- Unload with LOG2N=3 and out_ready_i toggling 1,0,1 -> 8 samples in address order 0..7, out_valid_o held through stalls, return to IDLE with no done_o.
- abort_i asserted in LOAD after 3 samples, and again in CALC -> IDLE next cycle, busy_o=0, no done_o. A fresh start_i restarts at write address 0.
- start_i and unload_i both high in IDLE -> LOAD. start_i pulsed during compute -> no effect on counters or state.
